filtre_kararli_tampon: RTL

- Downstream stage of the behavioural filter: consumes its 5-bit filtered code and accepts a code only after it has been stable for KARARLI_SAYI consecutive clock edges.
- Each accepted code that differs from the previously accepted one is pushed into a small show-ahead FIFO.
- The FIFO presents codes on a valid/ready output for the next consumer.
- Codes that arrive while the FIFO is full are counted as dropped.

---
 rtl/filtre_kararli_tampon_pkg.sv | 12 +
 rtl/filtre_kararli_tampon_fifo.sv | 45 ++++
 rtl/filtre_kararli_tampon.sv | 70 +++++++
 3 files changed

// File: rtl/filtre_kararli_tampon_pkg.sv
// Shared types and constants for the stable-code buffer that follows the filter.
package filtre_pkg;
  localparam int VERI_W_VARS = 5;

  typedef enum logic [1:0] {
    KARARSIZ = 2'd0,
    SAYIYOR  = 2'd1,
    KARARLI  = 2'd2
  } durum_t;

  localparam logic [7:0] KAYIP_DOYUM = 8'd255;
endpackage

// File: rtl/filtre_kararli_tampon_fifo.sv
// Small show-ahead FIFO; head is visible without a read, zero when empty.
module kucuk_fifo #(
  parameter int VERI_W   = 5,
  parameter int DERINLIK = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              yaz,
  input  logic              oku,
  input  logic [VERI_W-1:0] veri_i,
  output logic [VERI_W-1:0] veri_o,
  output logic              dolu,
  output logic              bos
);
  localparam int AW = $clog2(DERINLIK);

  logic [VERI_W-1:0] mem [DERINLIK];
  logic [AW-1:0]     yptr, optr;
  logic [AW:0]       adet;
  logic              oku_e, yaz_e;

  assign bos    = (adet == '0);
  assign dolu   = (adet == (AW+1)'(DERINLIK));
  assign oku_e  = oku & ~bos;
  // a full FIFO still takes a write when the head leaves on the same edge
  assign yaz_e  = yaz & (~dolu | oku_e);
  assign veri_o = bos ? '0 : mem[optr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      yptr <= '0;
      optr <= '0;
      adet <= '0;
    end else begin
      if (yaz_e) yptr <= yptr + 1'b1;
      if (oku_e) optr <= optr + 1'b1;
      if (yaz_e && !oku_e)      adet <= adet + 1'b1;
      else if (!yaz_e && oku_e) adet <= adet - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (yaz_e) mem[yptr] <= veri_i;
  end
endmodule

// File: rtl/filtre_kararli_tampon.sv
// Accepts a filtered code once it has been stable long enough and queues each new one.
module filtre_kararli_tampon
  import filtre_pkg::*;
#(
  parameter int VERI_W       = VERI_W_VARS,
  parameter int KARARLI_SAYI = 4,
  parameter int DERINLIK     = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [VERI_W-1:0] filtre_i,
  output logic [VERI_W-1:0] cikis_veri,
  output logic              cikis_gecerli,
  input  logic              cikis_hazir,
  output logic              dolu,
  output logic              bos,
  output logic [7:0]        kayip_sayac
);
  localparam logic [3:0] K = 4'(KARARLI_SAYI);

  logic [VERI_W-1:0] onceki, son_kabul;
  logic              son_kabul_gecerli;
  logic [3:0]        sayac, sayac_n;
  durum_t            durum, durum_n;
  logic              esit, kabul, itme, cekme, yaz, kayip;

  assign esit    = (filtre_i == onceki);
  assign sayac_n = !esit ? 4'd1 : (sayac == K) ? K : sayac + 4'd1;
  assign durum_n = (sayac_n == K)        ? KARARLI :
                   (sayac_n == K - 4'd1) ? SAYIYOR : KARARSIZ;

  // SAYIYOR plus one more equal sample is exactly the edge the count reaches K
  assign kabul = esit && (durum == SAYIYOR);
  assign itme  = kabul && (!son_kabul_gecerli || onceki != son_kabul);
  assign cekme = cikis_gecerli && cikis_hazir;
  assign yaz   = itme && (!dolu || cekme);
  assign kayip = itme && dolu && !cekme;
  assign cikis_gecerli = !bos;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      onceki            <= '0;
      sayac             <= '0;
      durum             <= KARARSIZ;
      son_kabul         <= '0;
      son_kabul_gecerli <= 1'b0;
      kayip_sayac       <= '0;
    end else begin
      onceki <= filtre_i;
      sayac  <= sayac_n;
      durum  <= durum_n;
      if (itme) begin
        son_kabul         <= onceki;
        son_kabul_gecerli <= 1'b1;
      end
      if (kayip && kayip_sayac != KAYIP_DOYUM) kayip_sayac <= kayip_sayac + 8'd1;
    end
  end

  kucuk_fifo #(.VERI_W(VERI_W), .DERINLIK(DERINLIK)) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .yaz    (yaz),
    .oku    (cekme),
    .veri_i (onceki),
    .veri_o (cikis_veri),
    .dolu   (dolu),
    .bos    (bos)
  );
endmodule
